// File: rtl/ctrl_charlieplex_scroll.sv
// Scroll sequencer: CPU-loaded column buffer, periodically rendered as five
// 7-bit row images and pushed to the charlieplex screen over Wishbone.
module ctrl_charlieplex_scroll #(
  parameter int unsigned ClkHz  = 48000000,
  parameter int unsigned StepHz = 10,
  parameter int unsigned BufLen = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wb_we_i,
  input  logic [5:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_stb_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       wbm_we_o,
  output logic [3:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  output logic       wbm_stb_o,
  input  logic       wbm_ack_i
);

  localparam int unsigned StepCycles = ClkHz / StepHz;
  localparam int unsigned DivW       = $clog2(StepCycles);
  localparam int unsigned AW         = (BufLen > 1) ? $clog2(BufLen) : 1;
  localparam logic [5:0]  BufLenW    = 6'(BufLen);
  localparam logic [DivW-1:0] DivLast = DivW'(StepCycles - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_WRITE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            enable_q, enable_d;
  logic            loop_q, loop_d;
  logic [5:0]      len_q, len_d;
  logic [4:0]      pos_q, pos_d;
  logic [4:0]      idx_q, idx_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [6:0]      rowimg_q, rowimg_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      buf_q [2**AW];

  logic       cpu_wr, buf_sel, ctrl_wr, len_wr, start;
  logic [5:0] pos_p1, idx_p1;
  logic [4:0] pos_next, idx_next;
  logic       gather_bit;

  function automatic logic [5:0] clamp_len(input logic [7:0] v);
    if (v == 8'd0) return 6'd1;
    if (v > {2'b00, BufLenW}) return BufLenW;
    return v[5:0];
  endfunction

  assign cpu_wr  = wb_stb_i & wb_we_i;
  assign buf_sel = (wb_adr_i < BufLenW);
  assign ctrl_wr = cpu_wr & (wb_adr_i == 6'h20);
  assign len_wr  = cpu_wr & (wb_adr_i == 6'h21);
  assign start   = ctrl_wr & wb_dat_i[0] & ~enable_q & (state_q == S_IDLE);

  // Both the window start (pos) and the scan index wrap modulo the active length.
  assign pos_p1   = {1'b0, pos_q} + 6'd1;
  assign idx_p1   = {1'b0, idx_q} + 6'd1;
  assign pos_next = (pos_p1 >= len_q) ? 5'd0 : pos_p1[4:0];
  assign idx_next = (idx_p1 >= len_q) ? 5'd0 : idx_p1[4:0];

  assign gather_bit = buf_q[idx_q[AW-1:0]][row_q];

  assign wb_ack_o  = wb_stb_i;
  assign wbm_stb_o = (state_q == S_WRITE);
  assign wbm_we_o  = (state_q == S_WRITE);
  assign wbm_adr_o = (state_q == S_WRITE) ? {1'b0, row_q} : 4'd0;
  assign wbm_dat_o = (state_q == S_WRITE) ? {1'b0, rowimg_q} : 8'd0;

  always_comb begin
    wb_dat_o = 8'd0;
    if (wb_stb_i) begin
      if (buf_sel) begin
        wb_dat_o = buf_q[wb_adr_i[AW-1:0]];
      end else begin
        case (wb_adr_i)
          6'h20:   wb_dat_o = {6'd0, loop_q, enable_q};
          6'h21:   wb_dat_o = {2'd0, len_q};
          6'h22:   wb_dat_o = {pos_q, 2'd0, (state_q != S_IDLE)};
          default: wb_dat_o = 8'd0;
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    loop_d   = loop_q;
    len_d    = len_q;
    pos_d    = pos_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    rowimg_d = rowimg_q;
    div_d    = div_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_d   = 5'd0;
          row_d   = 3'd0;
          col_d   = 3'd0;
          idx_d   = 5'd0;
          state_d = S_GATHER;
        end
      end
      S_GATHER: begin
        if (!enable_q) begin
          state_d = S_IDLE;
        end else begin
          rowimg_d[col_q] = gather_bit;
          idx_d = idx_next;
          col_d = col_q + 3'd1;
          if (col_q == 3'd6) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is held until acknowledged, even if disable arrives meanwhile.
        if (wbm_ack_i) begin
          if (!enable_q) begin
            state_d = S_IDLE;
          end else if (row_q != 3'd4) begin
            row_d   = row_q + 3'd1;
            col_d   = 3'd0;
            idx_d   = pos_q;
            state_d = S_GATHER;
          end else begin
            row_d = 3'd0;
            pos_d = pos_next;
            if (!loop_q && pos_next == 5'd0) begin
              enable_d = 1'b0;
              state_d  = S_IDLE;
            end else begin
              div_d   = '0;
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!enable_q) begin
          state_d = S_IDLE;
        end else if (div_q == DivLast) begin
          col_d   = 3'd0;
          idx_d   = pos_q;
          state_d = S_GATHER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU register writes take precedence over sequencer updates.
    if (ctrl_wr) begin
      enable_d = wb_dat_i[0];
      loop_d   = wb_dat_i[1];
    end
    if (len_wr) begin
      len_d = clamp_len(wb_dat_i);
      pos_d = 5'd0;
      idx_d = 5'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      loop_q   <= 1'b0;
      len_q    <= 6'd7;
      pos_q    <= 5'd0;
      idx_q    <= 5'd0;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      rowimg_q <= 7'd0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      loop_q   <= loop_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rowimg_q <= rowimg_d;
      div_q    <= div_d;
    end
  end

  // Pattern storage survives reset.
  always_ff @(posedge clk_i) begin
    if (cpu_wr && buf_sel) buf_q[wb_adr_i[AW-1:0]] <= wb_dat_i;
  end

endmodule
